// File: rtl/jelly2_wb_gpio_pwm_pkg.sv
// Shared constants for the Wishbone GPIO/PWM peripheral: register word addresses and core ID.
package jelly2_wb_gpio_pwm_pkg;

    localparam logic [5:0]  ADR_CORE_ID   = 6'h00;
    localparam logic [5:0]  ADR_OUT_DATA  = 6'h01;
    localparam logic [5:0]  ADR_OUT_SET   = 6'h02;
    localparam logic [5:0]  ADR_OUT_CLR   = 6'h03;
    localparam logic [5:0]  ADR_OUT_TOG   = 6'h04;
    localparam logic [5:0]  ADR_PWM_EN    = 6'h05;
    localparam logic [5:0]  ADR_PRESCALE  = 6'h06;
    localparam logic [5:0]  ADR_PERIOD    = 6'h07;
    localparam logic [5:0]  ADR_COUNTER   = 6'h08;
    localparam logic [5:0]  ADR_DUTY_BASE = 6'h20;

    localparam logic [31:0] CORE_ID       = 32'h527a_2f10;

endpackage

// File: rtl/jelly2_pwm_timebase.sv
// Shared PWM timebase: prescaler followed by a period counter that wraps when it reaches PERIOD.
module jelly2_pwm_timebase #(
    parameter int CNT_WIDTH = 16,
    parameter int PRE_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cke,
    input  logic [PRE_WIDTH-1:0] prescale,
    input  logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] counter,
    output logic                 tick,
    output logic                 wrap
);

    logic [PRE_WIDTH-1:0] pre_r;
    logic [CNT_WIDTH-1:0] counter_r;
    logic                 tick_s;
    logic                 wrap_s;

    // tick/wrap flags; >= comparisons keep a shrunk PRESCALE or PERIOD from running away
    always_comb begin
        tick_s = 1'b0;
        wrap_s = 1'b0;
        if (cke && (pre_r >= prescale)) begin
            tick_s = 1'b1;
            wrap_s = (counter_r >= period);
        end else begin
            tick_s = 1'b0;
            wrap_s = 1'b0;
        end
    end

    // prescaler and period counter state
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_r     <= '0;
            counter_r <= '0;
        end else if (cke) begin
            if (tick_s) begin
                pre_r     <= '0;
                counter_r <= wrap_s ? '0 : counter_r + CNT_WIDTH'(1);
            end else begin
                pre_r     <= pre_r + PRE_WIDTH'(1);
            end
        end
    end

    assign counter = counter_r;
    assign tick    = tick_s;
    assign wrap    = wrap_s;

endmodule

// File: rtl/jelly2_wb_gpio_pwm.sv
// Wishbone GPIO output bank with per-channel PWM from a shared timebase.
// Define JELLY2_WB_GPIO_PWM_SHADOW_EN to make DUTY writes take effect only on period wrap.
module jelly2_wb_gpio_pwm #(
    parameter int                     NUM_CH         = 8,
    parameter int                     S_WB_ADR_WIDTH = 8,
    parameter int                     S_WB_DAT_WIDTH = 32,
    parameter int                     CNT_WIDTH      = 16,
    parameter int                     PRE_WIDTH      = 16,
    parameter logic [NUM_CH-1:0]      INIT_OUT       = '0,
    parameter logic [CNT_WIDTH-1:0]   INIT_PERIOD    = CNT_WIDTH'(32'd255)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cke,
    input  logic [S_WB_ADR_WIDTH-1:0]     s_wb_adr_i,
    input  logic [S_WB_DAT_WIDTH-1:0]     s_wb_dat_i,
    output logic [S_WB_DAT_WIDTH-1:0]     s_wb_dat_o,
    input  logic [S_WB_DAT_WIDTH/8-1:0]   s_wb_sel_i,
    input  logic                          s_wb_we_i,
    input  logic                          s_wb_stb_i,
    output logic                          s_wb_ack_o,
    output logic [NUM_CH-1:0]             gpio_o
);
    import jelly2_wb_gpio_pwm_pkg::*;

    localparam int DW        = S_WB_DAT_WIDTH;
    localparam int AW        = S_WB_ADR_WIDTH;
    localparam int SEL_WIDTH = S_WB_DAT_WIDTH / 8;

    localparam logic [AW-1:0] A_CORE_ID   = AW'(ADR_CORE_ID);
    localparam logic [AW-1:0] A_OUT_DATA  = AW'(ADR_OUT_DATA);
    localparam logic [AW-1:0] A_OUT_SET   = AW'(ADR_OUT_SET);
    localparam logic [AW-1:0] A_OUT_CLR   = AW'(ADR_OUT_CLR);
    localparam logic [AW-1:0] A_OUT_TOG   = AW'(ADR_OUT_TOG);
    localparam logic [AW-1:0] A_PWM_EN    = AW'(ADR_PWM_EN);
    localparam logic [AW-1:0] A_PRESCALE  = AW'(ADR_PRESCALE);
    localparam logic [AW-1:0] A_PERIOD    = AW'(ADR_PERIOD);
    localparam logic [AW-1:0] A_COUNTER   = AW'(ADR_COUNTER);
    localparam logic [AW-1:0] A_DUTY_BASE = AW'(ADR_DUTY_BASE);

    function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] cur,
                                                  input logic [DW-1:0] wdat,
                                                  input logic [DW-1:0] mask);
        return (cur & ~mask) | (wdat & mask);
    endfunction

    logic [DW-1:0]        wmask_s;
    logic [DW-1:0]        wbits_s;
    logic [DW-1:0]        rdata_s;
    logic                 wr_en_s;
    logic [AW-1:0]        duty_off_s;
    logic                 duty_hit_s;

    logic [NUM_CH-1:0]    out_data_r;
    logic [NUM_CH-1:0]    pwm_en_r;
    logic [PRE_WIDTH-1:0] prescale_r;
    logic [CNT_WIDTH-1:0] period_r;
    logic [CNT_WIDTH-1:0] duty_r     [NUM_CH];
    logic [CNT_WIDTH-1:0] duty_act_s [NUM_CH];
    logic [NUM_CH-1:0]    pwm_s;
    logic [NUM_CH-1:0]    gpio_r;

    logic [CNT_WIDTH-1:0] counter_s;
    logic                 tick_s;
    logic                 wrap_s;
    logic                 unused_flags_s;

    jelly2_pwm_timebase #(
        .CNT_WIDTH (CNT_WIDTH),
        .PRE_WIDTH (PRE_WIDTH)
    ) u_timebase (
        .clk      (clk),
        .reset    (reset),
        .cke      (cke),
        .prescale (prescale_r),
        .period   (period_r),
        .counter  (counter_s),
        .tick     (tick_s),
        .wrap     (wrap_s)
    );

    assign unused_flags_s = tick_s ^ wrap_s;
    assign wr_en_s        = s_wb_stb_i & s_wb_we_i;

    // byte-lane write mask and DUTY window decode
    always_comb begin
        wmask_s = '0;
        for (int i = 0; i < SEL_WIDTH; i++) begin
            wmask_s[8*i +: 8] = {8{s_wb_sel_i[i]}};
        end
        wbits_s    = s_wb_dat_i & wmask_s;
        duty_off_s = s_wb_adr_i - A_DUTY_BASE;
        duty_hit_s = (s_wb_adr_i >= A_DUTY_BASE) && (duty_off_s < AW'(NUM_CH));
    end

    // combinational read mux, zero when idle or unmapped
    always_comb begin
        rdata_s = '0;
        if (s_wb_stb_i) begin
            case (s_wb_adr_i)
                A_CORE_ID:                                  rdata_s[31:0]           = CORE_ID;
                A_OUT_DATA, A_OUT_SET, A_OUT_CLR, A_OUT_TOG: rdata_s[NUM_CH-1:0]    = out_data_r;
                A_PWM_EN:                                   rdata_s[NUM_CH-1:0]     = pwm_en_r;
                A_PRESCALE:                                 rdata_s[PRE_WIDTH-1:0]  = prescale_r;
                A_PERIOD:                                   rdata_s[CNT_WIDTH-1:0]  = period_r;
                A_COUNTER:                                  rdata_s[CNT_WIDTH-1:0]  = counter_s;
                default: begin
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        if (duty_hit_s && (duty_off_s == AW'(ch))) begin
                            rdata_s[CNT_WIDTH-1:0] = duty_r[ch];
                        end else begin
                            rdata_s = rdata_s;
                        end
                    end
                end
            endcase
        end else begin
            rdata_s = '0;
        end
    end

    // register bank writes; reset wins over a coincident bus write
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_r <= INIT_OUT;
            pwm_en_r   <= '0;
            prescale_r <= '0;
            period_r   <= INIT_PERIOD;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                duty_r[ch] <= '0;
            end
        end else if (wr_en_s) begin
            case (s_wb_adr_i)
                A_OUT_DATA: out_data_r <= NUM_CH'(merge_lanes(DW'(out_data_r), s_wb_dat_i, wmask_s));
                A_OUT_SET:  out_data_r <= out_data_r |  wbits_s[NUM_CH-1:0];
                A_OUT_CLR:  out_data_r <= out_data_r & ~wbits_s[NUM_CH-1:0];
                A_OUT_TOG:  out_data_r <= out_data_r ^  wbits_s[NUM_CH-1:0];
                A_PWM_EN:   pwm_en_r   <= NUM_CH'(merge_lanes(DW'(pwm_en_r), s_wb_dat_i, wmask_s));
                A_PRESCALE: prescale_r <= PRE_WIDTH'(merge_lanes(DW'(prescale_r), s_wb_dat_i, wmask_s));
                A_PERIOD:   period_r   <= CNT_WIDTH'(merge_lanes(DW'(period_r), s_wb_dat_i, wmask_s));
                default: begin
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        if (duty_hit_s && (duty_off_s == AW'(ch))) begin
                            duty_r[ch] <= CNT_WIDTH'(merge_lanes(DW'(duty_r[ch]), s_wb_dat_i, wmask_s));
                        end
                    end
                end
            endcase
        end
    end

`ifdef JELLY2_WB_GPIO_PWM_SHADOW_EN
    logic [CNT_WIDTH-1:0] duty_act_r [NUM_CH];

    // active duty reloads from the shadow copy only at period wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                duty_act_r[ch] <= '0;
            end
        end else if (wrap_s) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                duty_act_r[ch] <= duty_r[ch];
            end
        end
    end

    // compare against the wrap-aligned copy
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            duty_act_s[ch] = duty_act_r[ch];
        end
    end
`else
    // compare directly against the written duty
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            duty_act_s[ch] = duty_r[ch];
        end
    end
`endif

    // per-channel PWM compare
    always_comb begin
        pwm_s = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            pwm_s[ch] = (counter_s < duty_act_s[ch]);
        end
    end

    // output flop selecting PWM or static level per channel
    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_r <= INIT_OUT;
        end else begin
            gpio_r <= (pwm_en_r & pwm_s) | (~pwm_en_r & out_data_r);
        end
    end

    assign gpio_o     = gpio_r;
    assign s_wb_ack_o = s_wb_stb_i;
    assign s_wb_dat_o = rdata_s;

endmodule

// File: tb/tb_jelly2_wb_gpio_pwm.sv
// Scoreboard bench for jelly2_wb_gpio_pwm: drivers queue expected reads/outputs, a negedge monitor compares.
module tb_jelly2_wb_gpio_pwm;

    logic        clk = 1'b0;
    logic        reset;
    logic        cke;
    logic [7:0]  adr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic        ack;
    logic [7:0]  gpio;

    int          errors = 0;
    int          checks = 0;

    logic [31:0] rd_q[$];
    string       rd_nm[$];
    logic [7:0]  gp_q[$];
    string       gp_nm[$];
    logic        gp_chk = 1'b0;

    jelly2_wb_gpio_pwm #(
        .NUM_CH         (8),
        .S_WB_ADR_WIDTH (8),
        .S_WB_DAT_WIDTH (32),
        .CNT_WIDTH      (16),
        .PRE_WIDTH      (16),
        .INIT_OUT       (8'h5A),
        .INIT_PERIOD    (16'd255)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cke        (cke),
        .s_wb_adr_i (adr),
        .s_wb_dat_i (dat_i),
        .s_wb_dat_o (dat_o),
        .s_wb_sel_i (sel),
        .s_wb_we_i  (we),
        .s_wb_stb_i (stb),
        .s_wb_ack_o (ack),
        .gpio_o     (gpio)
    );

    always #5 clk = ~clk;

    // monitor: ack every cycle, reads and gpio samples whenever presented
    always @(negedge clk) begin
        logic [31:0] er;
        logic [7:0]  eg;
        string       nm;
        checks++;
        if (ack !== stb) begin
            errors++;
            $display("FAIL ack: ack=%b required %b at %0t", ack, stb, $time);
        end
        if (stb === 1'b1 && we === 1'b0) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL read_underflow: unexpected read of 0x%02h", adr);
            end else begin
                er = rd_q.pop_front();
                nm = rd_nm.pop_front();
                if (dat_o !== er) begin
                    errors++;
                    $display("FAIL %s: read 0x%08h required 0x%08h", nm, dat_o, er);
                end
            end
        end
        if (gp_chk) begin
            checks++;
            if (gp_q.size() == 0) begin
                errors++;
                $display("FAIL gpio_underflow: no expected value queued");
            end else begin
                eg = gp_q.pop_front();
                nm = gp_nm.pop_front();
                if (gpio !== eg) begin
                    errors++;
                    $display("FAIL %s: gpio 0x%02h required 0x%02h at %0t", nm, gpio, eg, $time);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        adr = a; dat_i = d; sel = s; we = 1'b1; stb = 1'b1;
        @(posedge clk);
        #1;
        stb = 1'b0; we = 1'b0; sel = 4'hF; dat_i = 32'h0;
    endtask

    task automatic wb_read(input logic [7:0] a, input logic [31:0] e, input string nm);
        adr = a; we = 1'b0; stb = 1'b1;
        rd_q.push_back(e);
        rd_nm.push_back(nm);
        @(posedge clk);
        #1;
        stb = 1'b0;
    endtask

    task automatic chk_gpio(input logic [7:0] e, input string nm);
        gp_q.push_back(e);
        gp_nm.push_back(nm);
        gp_chk = 1'b1;
        @(posedge clk);
        #1;
        gp_chk = 1'b0;
    endtask

    task automatic run_cke(input int n);
        cke = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        cke = 1'b0;
    endtask

    task automatic wait_rise(input string nm);
        logic prev;
        bit   ok;
        ok   = 1'b0;
        prev = gpio[0];
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (gpio[0] && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = gpio[0];
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: no rising edge within 60 cycles, required one", nm);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] shadow_mid;
        logic [7:0] shadow_wrap;
`ifdef JELLY2_WB_GPIO_PWM_SHADOW_EN
        shadow_mid  = 8'h32;
        shadow_wrap = 8'h33;
`else
        shadow_mid  = 8'h33;
        shadow_wrap = 8'h32;
`endif
        reset = 1'b1; cke = 1'b1; adr = 8'h0; dat_i = 32'h0; sel = 4'hF; we = 1'b0; stb = 1'b0;
        idle(3);
        reset = 1'b0;

        // reset state
        chk_gpio(8'h5A, "reset_gpio");
        wb_read(8'h01, 32'h5A, "reset_out_data");
        wb_read(8'h07, 32'd255, "reset_period");
        wb_read(8'h05, 32'h0, "reset_pwm_en");
        wb_read(8'h06, 32'h0, "reset_prescale");
        wb_read(8'h00, 32'h527a_2f10, "core_id");

        // set / clear / toggle, gpio follows two cycles after each write
        wb_write(8'h02, 32'h01, 4'hF);
        chk_gpio(8'h5A, "set_latency");
        chk_gpio(8'h5B, "set_gpio");
        wb_write(8'h03, 32'h40, 4'hF);
        chk_gpio(8'h5B, "clr_latency");
        chk_gpio(8'h1B, "clr_gpio");
        wb_write(8'h04, 32'hFF, 4'hF);
        chk_gpio(8'h1B, "tog_latency");
        chk_gpio(8'hE4, "tog_gpio");
        wb_read(8'h04, 32'hE4, "read_tog");

        // PWM waveform: 20 clk period, 6 clk high
        wb_write(8'h06, 32'd1, 4'hF);
        wb_write(8'h07, 32'd9, 4'hF);
        wb_write(8'h20, 32'd3, 4'hF);
        wb_write(8'h05, 32'h01, 4'hF);
        wait_rise("pwm_first_rise");
        wait_rise("pwm_second_rise");
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 6; i++)  chk_gpio(8'hE5, "pwm_high");
            for (int i = 0; i < 14; i++) chk_gpio(8'hE4, "pwm_low");
        end
        wb_write(8'h20, 32'd0, 4'hF);
        idle(25);
        for (int i = 0; i < 20; i++) chk_gpio(8'hE4, "duty0_const_low");
        wb_write(8'h20, 32'd10, 4'hF);
        idle(25);
        for (int i = 0; i < 20; i++) chk_gpio(8'hE5, "duty_gt_period_high");
        wb_read(8'h20, 32'd10, "duty_readback");

        // unmapped addresses and byte lanes
        wb_write(8'h28, 32'hFFFF, 4'hF);
        wb_read(8'h28, 32'h0, "unmapped_ch8");
        wb_write(8'h3F, 32'hFFFF, 4'hF);
        wb_read(8'h3F, 32'h0, "unmapped_3f");
        wb_read(8'h27, 32'h0, "duty7_untouched");
        wb_write(8'h07, 32'hFFFF, 4'b0001);
        wb_read(8'h07, 32'h00FF, "period_sel_lane0");

        // reset mid-operation with a coincident write, timebase frozen afterwards
        cke = 1'b0;
        reset = 1'b1; adr = 8'h01; dat_i = 32'hFF; sel = 4'hF; we = 1'b1; stb = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; we = 1'b0; stb = 1'b0;
        chk_gpio(8'h5A, "midreset_gpio");
        wb_read(8'h01, 32'h5A, "midreset_out_data");
        wb_read(8'h05, 32'h0, "midreset_pwm_en");
        wb_read(8'h20, 32'h0, "midreset_duty");
        wb_read(8'h07, 32'd255, "midreset_period");
        wb_read(8'h08, 32'h0, "midreset_counter");

        // PERIOD shrink below current count wraps on next tick
        wb_write(8'h07, 32'd9, 4'hF);
        run_cke(8);
        wb_read(8'h08, 32'd8, "counter_at_8");
        wb_write(8'h07, 32'd4, 4'hF);
        run_cke(1);
        wb_read(8'h08, 32'd0, "shrink_wrap");
        run_cke(4);
        wb_read(8'h08, 32'd4, "short_period_top");
        run_cke(1);
        wb_read(8'h08, 32'd0, "short_period_wrap");

        // cke low: counter frozen, register writes still land
        wb_write(8'h01, 32'h32, 4'hF);
        idle(50);
        wb_read(8'h08, 32'd0, "frozen_counter");
        wb_read(8'h01, 32'h32, "frozen_write");
        chk_gpio(8'h32, "frozen_gpio");

        // duty update timing (shadowed or immediate)
        wb_write(8'h07, 32'd9, 4'hF);
        wb_write(8'h20, 32'd3, 4'hF);
        wb_write(8'h05, 32'h01, 4'hF);
        run_cke(10);
        idle(1);
        chk_gpio(8'h33, "duty3_start");
        run_cke(5);
        idle(1);
        chk_gpio(8'h32, "duty3_count5");
        wb_write(8'h20, 32'd7, 4'hF);
        idle(1);
        chk_gpio(shadow_mid, "midperiod_duty7");
        run_cke(5);
        idle(1);
        chk_gpio(8'h33, "after_wrap_duty7");
        run_cke(9);
        cke = 1'b1;
        wb_write(8'h20, 32'd2, 4'hF);
        cke = 1'b0;
        run_cke(5);
        idle(1);
        chk_gpio(shadow_wrap, "wrap_coincident_write");
        run_cke(5);
        idle(1);
        chk_gpio(8'h33, "next_wrap_start");
        run_cke(2);
        idle(1);
        chk_gpio(8'h32, "duty2_count2");
        wb_read(8'h20, 32'd2, "duty_shadow_read");

        idle(2);
        checks++;
        if (rd_q.size() != 0 || gp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d reads and %0d gpio samples left, required 0", rd_q.size(), gp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
